// File: rtl/slave_bram_ctrl.sv
// slave_bram_ctrl: single-request synchronous RAM back-end behind slave_port_v2.
// Write done 1 edge after accept, read valid RD_LATENCY edges after accept; optional SLAVE_BRAM_BOUNDS_EN.
module slave_bram_ctrl #(
   parameter int ADDR_W     = 12,
   parameter int DATA_W     = 8,
   parameter int DEPTH      = 2048,
   parameter int RD_LATENCY = 2
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              s_req,
   input  logic              s_mode,
   input  logic [ADDR_W-1:0] s_addr,
   input  logic [DATA_W-1:0] s_wr_data,
   output logic              s_ready,
   output logic [DATA_W-1:0] s_rd_data,
   output logic              s_rd_valid,
   output logic              s_wr_done,
   output logic              s_err
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = 3;
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(RD_LATENCY - 1);

   typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;

   state_t            state_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [DATA_W-1:0] rd_data_q;
   logic              ready_q;
   logic              rd_valid_q;
   logic              wr_done_q;
   logic              err_q;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [IDX_W-1:0]  idx;
   logic              oob;
   logic              mem_we;

`ifdef SLAVE_BRAM_BOUNDS_EN
   localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
   assign oob = ({1'b0, addr_q} >= DEPTH_C);
`else
   // Out-of-range offsets alias into the RAM through the low index bits.
   logic unused_addr;
   assign unused_addr = ^addr_q;
   assign oob = 1'b0;
`endif

   assign idx    = addr_q[IDX_W-1:0];
   assign mem_we = (state_q == WRITE) && !oob;

   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[idx] <= wdata_q;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         addr_q     <= '0;
         wdata_q    <= '0;
         rd_data_q  <= '0;
         ready_q    <= 1'b0;
         rd_valid_q <= 1'b0;
         wr_done_q  <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         rd_valid_q <= 1'b0;
         wr_done_q  <= 1'b0;
         err_q      <= 1'b0;
         case (state_q)
            IDLE: begin
               if (s_req && ready_q) begin
                  addr_q  <= s_addr;
                  wdata_q <= s_wr_data;
                  cnt_q   <= CNT_INIT;
                  ready_q <= 1'b0;
                  state_q <= s_mode ? WRITE : READ;
               end else begin
                  ready_q <= 1'b1;
               end
            end
            WRITE: begin
               wr_done_q <= !oob;
               err_q     <= oob;
               ready_q   <= 1'b1;
               state_q   <= IDLE;
            end
            READ: begin
               if (cnt_q == '0) begin
                  rd_data_q  <= oob ? {DATA_W{1'b1}} : mem[idx];
                  rd_valid_q <= 1'b1;
                  err_q      <= oob;
                  ready_q    <= 1'b1;
                  state_q    <= IDLE;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            default: begin
               ready_q <= 1'b1;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign s_ready    = ready_q;
   assign s_rd_data  = rd_data_q;
   assign s_rd_valid = rd_valid_q;
   assign s_wr_done  = wr_done_q;
   assign s_err      = err_q;

endmodule

// File: tb/tb_slave_bram_ctrl.sv
// Bench for slave_bram_ctrl: directed scenarios plus randomized traffic against an array model;
// a second instance runs with RD_LATENCY=1.
`timescale 1ns/1ps
module tb_slave_bram_ctrl;

   localparam int ADDR_W = 12;
   localparam int DATA_W = 8;
   localparam int DEPTH  = 2048;
   localparam int LAT    = 2;

   logic clk  = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;

   logic              s_req = 1'b0, s_mode = 1'b0;
   logic [ADDR_W-1:0] s_addr = '0;
   logic [DATA_W-1:0] s_wr_data = '0;
   logic              s_ready, s_rd_valid, s_wr_done, s_err;
   logic [DATA_W-1:0] s_rd_data;

   logic              s_req1 = 1'b0, s_mode1 = 1'b0;
   logic [ADDR_W-1:0] s_addr1 = '0;
   logic [DATA_W-1:0] s_wr_data1 = '0;
   logic              s_ready1, s_rd_valid1, s_wr_done1, s_err1;
   logic [DATA_W-1:0] s_rd_data1;

   int n_tests = 0;
   int n_fail  = 0;

   logic [DATA_W-1:0] ref_mem [int];
   logic prev_valid = 1'b0, prev_done = 1'b0;

   slave_bram_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .RD_LATENCY(LAT)) u_dut (
      .clk(clk), .rstn(rstn), .s_req(s_req), .s_mode(s_mode), .s_addr(s_addr),
      .s_wr_data(s_wr_data), .s_ready(s_ready), .s_rd_data(s_rd_data),
      .s_rd_valid(s_rd_valid), .s_wr_done(s_wr_done), .s_err(s_err));

   slave_bram_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .RD_LATENCY(1)) u_dut1 (
      .clk(clk), .rstn(rstn), .s_req(s_req1), .s_mode(s_mode1), .s_addr(s_addr1),
      .s_wr_data(s_wr_data1), .s_ready(s_ready1), .s_rd_data(s_rd_data1),
      .s_rd_valid(s_rd_valid1), .s_wr_done(s_wr_done1), .s_err(s_err1));

   // Reference model: a word array indexed by effective address.
   function automatic bit is_oob(input logic [ADDR_W-1:0] a);
`ifdef SLAVE_BRAM_BOUNDS_EN
      return int'(a) >= DEPTH;
`else
      return 1'b0;
`endif
   endfunction

   function automatic int eff(input logic [ADDR_W-1:0] a);
      return int'(a) % DEPTH;
   endfunction

   task automatic model_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      if (!is_oob(a)) ref_mem[eff(a)] = d;
   endtask

   // Strobe monitor: pulses last one cycle and never overlap.
   always @(negedge clk) begin
      if (rstn && s_rd_valid) begin
         n_tests++;
         if (s_wr_done !== 1'b0) begin
            n_fail++;
            $display("FAIL strobe_overlap got wr_done=%b exp 0 while rd_valid", s_wr_done);
         end
      end
      if (rstn && prev_valid) begin
         n_tests++;
         if (s_rd_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rd_valid_width got %b exp 0 on second cycle", s_rd_valid);
         end
      end
      if (rstn && prev_done) begin
         n_tests++;
         if (s_wr_done !== 1'b0) begin
            n_fail++;
            $display("FAIL wr_done_width got %b exp 0 on second cycle", s_wr_done);
         end
      end
      prev_valid = rstn && s_rd_valid;
      prev_done  = rstn && s_wr_done;
   end

   // One request on instance sel; reports wait cycles, completion edge count and outputs.
   task automatic xact(input bit sel, input logic mode, input logic [ADDR_W-1:0] addr,
                       input logic [DATA_W-1:0] data, output int waited, output int lat,
                       output logic busy0, output logic [DATA_W-1:0] rdata,
                       output logic err, output logic done);
      waited = 0; lat = -1; busy0 = 1'b0; rdata = '0; err = 1'b0; done = 1'b0;
      @(negedge clk);
      while (!(sel ? s_ready1 : s_ready) && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      if (!(sel ? s_ready1 : s_ready)) begin
         waited = -1;
         return;
      end
      if (sel) begin
         s_req1 = 1'b1; s_mode1 = mode; s_addr1 = addr; s_wr_data1 = data;
      end else begin
         s_req = 1'b1; s_mode = mode; s_addr = addr; s_wr_data = data;
      end
      @(posedge clk); #1;
      s_req = 1'b0; s_req1 = 1'b0;
      busy0 = !(sel ? s_ready1 : s_ready);
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk); #1;
         if (sel ? (s_rd_valid1 || s_wr_done1 || s_err1) : (s_rd_valid || s_wr_done || s_err)) begin
            lat   = i;
            rdata = sel ? s_rd_data1 : s_rd_data;
            err   = sel ? s_err1 : s_err;
            done  = sel ? s_wr_done1 : s_wr_done;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      #20;
      n_tests++;
      if (s_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got %b exp 0", s_ready); end
      n_tests++;
      if ({s_rd_valid, s_wr_done, s_err} !== 3'b000) begin
         n_fail++; $display("FAIL reset_strobes got %b exp 000", {s_rd_valid, s_wr_done, s_err});
      end
      n_tests++;
      if (s_rd_data !== 8'h00) begin n_fail++; $display("FAIL reset_rd_data got %h exp 00", s_rd_data); end
      @(negedge clk);
      rstn = 1'b1;
      repeat (2) @(negedge clk);
      n_tests++;
      if (s_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready got %b exp 1", s_ready); end
   endtask

   task automatic test_write_read();
      int w, l; logic b, e, d; logic [DATA_W-1:0] r;
      xact(0, 1'b1, 12'h234, 8'h5A, w, l, b, r, e, d);
      model_write(12'h234, 8'h5A);
      n_tests++;
      if (b !== 1'b1) begin n_fail++; $display("FAIL wr_busy got ready=%b exp 0", !b); end
      n_tests++;
      if (l != 1 || d !== 1'b1 || e !== 1'b0) begin
         n_fail++; $display("FAIL wr_done_latency got lat=%0d done=%b err=%b exp lat=1 done=1 err=0", l, d, e);
      end
      xact(0, 1'b0, 12'h234, 8'h00, w, l, b, r, e, d);
      n_tests++;
      if (l != LAT || r !== 8'h5A) begin
         n_fail++; $display("FAIL rd_basic got lat=%0d data=%h exp lat=%0d data=5a", l, r, LAT);
      end
      repeat (3) @(negedge clk);
      n_tests++;
      if (s_rd_data !== 8'h5A || s_rd_valid !== 1'b0) begin
         n_fail++; $display("FAIL rd_hold got data=%h valid=%b exp 5a 0", s_rd_data, s_rd_valid);
      end
   endtask

   task automatic test_back_to_back();
      int w, l; logic b, e, d; logic [DATA_W-1:0] r;
      xact(0, 1'b1, 12'h010, 8'h11, w, l, b, r, e, d);
      model_write(12'h010, 8'h11);
      n_tests++;
      if (l != 1) begin n_fail++; $display("FAIL b2b_wr got lat=%0d exp 1", l); end
      xact(0, 1'b0, 12'h010, 8'h00, w, l, b, r, e, d);
      n_tests++;
      if (w != 0) begin n_fail++; $display("FAIL b2b_accept got waited=%0d exp 0", w); end
      n_tests++;
      if (l != LAT || r !== 8'h11) begin
         n_fail++; $display("FAIL b2b_rd got lat=%0d data=%h exp lat=%0d data=11", l, r, LAT);
      end
   endtask

   task automatic test_ignored();
      int w, l; logic b, e, d; logic [DATA_W-1:0] r;
      logic seen_done = 1'b0, seen_valid = 1'b0;
      logic [DATA_W-1:0] got = '0;
      @(negedge clk);
      s_req = 1'b1; s_mode = 1'b0; s_addr = 12'h010;
      @(posedge clk); #1;
      s_req = 1'b0;
      @(negedge clk);
      n_tests++;
      if (s_ready !== 1'b0) begin n_fail++; $display("FAIL ign_busy got ready=%b exp 0", s_ready); end
      s_req = 1'b1; s_mode = 1'b1; s_addr = 12'h010; s_wr_data = 8'hEE;
      @(posedge clk); #1;
      s_req = 1'b0; s_mode = 1'b0;
      if (s_rd_valid) begin seen_valid = 1'b1; got = s_rd_data; end
      for (int i = 0; i < LAT + 3; i++) begin
         if (s_wr_done) seen_done = 1'b1;
         @(posedge clk); #1;
         if (s_rd_valid) begin seen_valid = 1'b1; got = s_rd_data; end
      end
      n_tests++;
      if (seen_done !== 1'b0) begin n_fail++; $display("FAIL ign_no_write got wr_done=%b exp 0", seen_done); end
      n_tests++;
      if (seen_valid !== 1'b1 || got !== 8'h11) begin
         n_fail++; $display("FAIL ign_rd got valid=%b data=%h exp 1 11", seen_valid, got);
      end
      xact(0, 1'b0, 12'h010, 8'h00, w, l, b, r, e, d);
      n_tests++;
      if (r !== 8'h11) begin n_fail++; $display("FAIL ign_reread got %h exp 11", r); end
   endtask

   task automatic test_reset_mid();
      int w, l; logic b, e, d; logic [DATA_W-1:0] r;
      logic seen = 1'b0;
      xact(0, 1'b1, 12'h020, 8'h33, w, l, b, r, e, d);
      model_write(12'h020, 8'h33);
      @(negedge clk);
      s_req = 1'b1; s_mode = 1'b0; s_addr = 12'h020;
      @(posedge clk); #1;
      s_req = 1'b0;
      rstn = 1'b0;
      #1;
      n_tests++;
      if (s_rd_data !== 8'h00 || s_rd_valid !== 1'b0) begin
         n_fail++; $display("FAIL rstmid_rd got data=%h valid=%b exp 00 0", s_rd_data, s_rd_valid);
      end
      @(negedge clk);
      rstn = 1'b1;
      for (int i = 0; i < LAT + 3; i++) begin
         @(posedge clk); #1;
         if (s_rd_valid) seen = 1'b1;
      end
      n_tests++;
      if (seen !== 1'b0 || s_ready !== 1'b1) begin
         n_fail++; $display("FAIL rstmid_after got valid_seen=%b ready=%b exp 0 1", seen, s_ready);
      end
      @(negedge clk);
      s_req = 1'b1; s_mode = 1'b1; s_addr = 12'h020; s_wr_data = 8'h77;
      @(posedge clk); #1;
      s_req = 1'b0; s_mode = 1'b0;
      rstn = 1'b0;
      @(negedge clk);
      rstn = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         if (s_wr_done) seen = 1'b1;
      end
      n_tests++;
      if (seen !== 1'b0) begin n_fail++; $display("FAIL rstmid_wr_done got %b exp 0", seen); end
      xact(0, 1'b0, 12'h020, 8'h00, w, l, b, r, e, d);
      n_tests++;
      if (r !== 8'h33) begin n_fail++; $display("FAIL rstmid_wr_abort got %h exp 33", r); end
   endtask

   task automatic test_out_of_range();
      int w, l; logic b, e, d; logic [DATA_W-1:0] r;
      logic [ADDR_W-1:0] ra;
      logic oob;
      oob = is_oob(12'h900);
      xact(0, 1'b1, 12'h900, 8'hC3, w, l, b, r, e, d);
      model_write(12'h900, 8'hC3);
      n_tests++;
      if (l != 1 || e !== oob || d !== !oob) begin
         n_fail++; $display("FAIL oob_wr got lat=%0d err=%b done=%b exp 1 %b %b", l, e, d, oob, !oob);
      end
      ra = oob ? 12'h900 : 12'h100;
      xact(0, 1'b0, ra, 8'h00, w, l, b, r, e, d);
      n_tests++;
      if (l != LAT || e !== oob || r !== (oob ? 8'hFF : 8'hC3)) begin
         n_fail++; $display("FAIL oob_rd got lat=%0d err=%b data=%h exp %0d %b %h",
                            l, e, r, LAT, oob, oob ? 8'hFF : 8'hC3);
      end
   endtask

   task automatic test_random();
      int w, l; logic b, e, d; logic [DATA_W-1:0] r;
      logic m; logic [ADDR_W-1:0] a; logic [DATA_W-1:0] wd;
      for (int n = 0; n < 60; n++) begin
         m  = 1'($urandom_range(0, 1));
         a  = ADDR_W'($urandom_range(0, 7) * 16 + ($urandom_range(0, 1) ? 12'h800 : 12'h000));
         wd = DATA_W'($urandom);
         xact(0, m, a, wd, w, l, b, r, e, d);
         n_tests++;
         if (l != (m ? 1 : LAT) || e !== is_oob(a)) begin
            n_fail++; $display("FAIL rand_timing n=%0d mode=%b addr=%h got lat=%0d err=%b exp %0d %b",
                               n, m, a, l, e, m ? 1 : LAT, is_oob(a));
         end
         if (m) begin
            model_write(a, wd);
         end else if (is_oob(a)) begin
            n_tests++;
            if (r !== 8'hFF) begin n_fail++; $display("FAIL rand_oob_rd addr=%h got %h exp ff", a, r); end
         end else if (ref_mem.exists(eff(a))) begin
            n_tests++;
            if (r !== ref_mem[eff(a)]) begin
               n_fail++; $display("FAIL rand_rd addr=%h got %h exp %h", a, r, ref_mem[eff(a)]);
            end
         end
      end
   endtask

   task automatic test_latency1();
      int w, l; logic b, e, d; logic [DATA_W-1:0] r;
      logic [ADDR_W-1:0] addrs [2];
      logic [DATA_W-1:0] vals [2];
      addrs[0] = 12'h234; vals[0] = 8'h5A;
      addrs[1] = 12'h3FF; vals[1] = 8'hA5;
      for (int k = 0; k < 2; k++) begin
         xact(1, 1'b1, addrs[k], vals[k], w, l, b, r, e, d);
         n_tests++;
         if (l != 1 || d !== 1'b1) begin
            n_fail++; $display("FAIL lat1_wr k=%0d got lat=%0d done=%b exp 1 1", k, l, d);
         end
         xact(1, 1'b0, addrs[k], 8'h00, w, l, b, r, e, d);
         n_tests++;
         if (l != 1 || r !== vals[k] || w != 0) begin
            n_fail++; $display("FAIL lat1_rd k=%0d got lat=%0d data=%h waited=%0d exp 1 %h 0",
                               k, l, r, w, vals[k]);
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got timeout exp completion");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_write_read();
      test_back_to_back();
      test_ignored();
      test_reset_mid();
      test_out_of_range();
      test_random();
      test_latency1();
      repeat (2) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
